// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed integer divider using a non-restoring
// shift/add-subtract loop on operand magnitudes, followed by sign correction.
// Quotient feeds LO and remainder feeds HI; done strobes their write enables.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP,
    DONE
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]    count;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs_mag;
  logic             q_neg;
  logic             r_neg;

  logic             divisor_zero;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   step_p;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;

  // Operand magnitudes, one non-restoring step, and the final sign/remainder fixup.
  always_comb begin
    divisor_zero = (divisor == '0);
    dvd_abs      = dividend[WIDTH-1] ? -dividend : dividend;
    dvs_abs      = divisor[WIDTH-1]  ? -divisor  : divisor;
    shifted      = {prem[WIDTH-1:0], quo[WIDTH-1]};
    step_p       = prem[WIDTH] ? (shifted + {1'b0, dvs_mag})
                               : (shifted - {1'b0, dvs_mag});
    rem_mag      = prem[WIDTH] ? (prem[WIDTH-1:0] + dvs_mag) : prem[WIDTH-1:0];
    fix_q        = q_neg ? -quo : quo;
    fix_r        = r_neg ? -rem_mag : rem_mag;
  end

  // State register; clr forces IDLE and aborts any division in flight.
  always_ff @(posedge clk) begin
    if (!clr) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state selection plus busy/done decoded from the current state.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) next_state = divisor_zero ? DONE : RUN;
      RUN:   if (count == LAST_STEP) next_state = FIXUP;
      FIXUP: next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath: latch operands on accept, iterate in RUN, publish results entering DONE.
  always_ff @(posedge clk) begin
    if (!clr) begin
      count       <= '0;
      prem        <= '0;
      quo         <= '0;
      dvs_mag     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              count   <= '0;
              prem    <= '0;
              quo     <= dvd_abs;
              dvs_mag <= dvs_abs;
              q_neg   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              r_neg   <= dividend[WIDTH-1];
            end
          end
        end
        RUN: begin
          prem  <= step_p;
          quo   <= {quo[WIDTH-2:0], ~step_p[WIDTH]};
          count <= count + 1'b1;
        end
        FIXUP: begin
          quotient    <= fix_q;
          remainder   <= fix_r;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors with hand-computed results for seq_divider.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk),
    .clr(clr),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Present operands with start for one edge; returns just after the accepting edge.
  task automatic startOp(input logic [31:0] a, input logic [31:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen, bounded so a stuck DUT cannot hang the run.
  task automatic waitDone(output int edges);
    edges = 0;
    while (!done && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_q, input logic [31:0] exp_r,
                               input logic exp_dz, input int exp_lat);
    int n;
    startOp(a, b);
    waitDone(n);
    checkOutput({tag, "_latency"}, 32'(n), 32'(exp_lat));
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    checkOutput({tag, "_quotient"}, quotient, exp_q);
    checkOutput({tag, "_remainder"}, remainder, exp_r);
    checkOutput({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(exp_dz));
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_after"}, 32'(done), 32'd0);
    checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
    checkOutput({tag, "_quotient_held"}, quotient, exp_q);
  endtask

  task automatic checkNoDone(input string tag, input int span);
    int pulses;
    pulses = 0;
    for (int i = 0; i < span; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    checkOutput(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    int n;

    clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_quotient", quotient, 32'd0);
    checkOutput("reset_remainder", remainder, 32'd0);
    checkOutput("reset_dz", 32'(div_by_zero), 32'd0);
    clr = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);

    applyStimulus("m7_2",   32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    applyStimulus("d7_m2",  32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,         1'b0, 33);
    applyStimulus("m7_m2",  32'hFFFF_FFF9, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 1'b0, 33);

    applyStimulus("min_m1", 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0, 33);
    applyStimulus("d0_5",   32'd0,         32'd5,          32'd0,         32'd0,         1'b0, 33);
    applyStimulus("d5_min", 32'd5,         32'h8000_0000,  32'd0,         32'd5,         1'b0, 33);
    applyStimulus("min_7",  32'h8000_0000, 32'd7,          32'hEDB6_DB6E, 32'hFFFF_FFFE, 1'b0, 33);

    applyStimulus("d5_0",   32'd5,         32'd0,          32'hFFFF_FFFF, 32'd5,         1'b1, 0);
    applyStimulus("clr_dz", 32'd9,         32'd3,          32'd3,         32'd0,         1'b0, 33);

    // A start arriving mid-division must be dropped.
    startOp(32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(n);
    checkOutput("ignore_latency", 32'(n + 10), 32'd33);
    checkOutput("ignore_quotient", quotient, 32'd14);
    checkOutput("ignore_remainder", remainder, 32'd2);
    checkNoDone("ignore_no_second_done", 45);

    // Reset mid-division aborts with no done.
    startOp(32'd100, 32'd7);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    clr = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_quotient", quotient, 32'd0);
    checkOutput("abort_remainder", remainder, 32'd0);
    checkOutput("abort_dz", 32'(div_by_zero), 32'd0);
    clr = 1'b1;
    checkNoDone("abort_no_done", 40);
    applyStimulus("after_abort", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
